// File: rtl/log_pkg.sv
// Shared constants and FSM state encoding for the sample-logger readout path.
package log_pkg;
    localparam int LOG_ADDR_WIDTH = 15;
    localparam int LOG_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD = LOG_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FETCH,
        SEND,
        DONE
    } dump_state_t;

    function automatic int bytes_per_word(input int dw);
        return dw / 8;
    endfunction
endpackage

// File: rtl/word_serializer.sv
// Loads one logger word and emits it MSB-first as bytes over a valid/ready handshake.
module word_serializer
    import log_pkg::*;
#(
    parameter int DATA_WIDTH = LOG_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    output logic [7:0]            tx_byte,
    output logic                  valid,
    output logic                  last
);
    localparam int NBYTES = bytes_per_word(DATA_WIDTH);
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      remain;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            shreg  <= '0;
            valid  <= 1'b0;
            remain <= '0;
        end else if (load) begin
            shreg  <= load_data;
            valid  <= 1'b1;
            remain <= CNT_W'(NBYTES - 1);
        end else if (valid && ready) begin
            shreg <= shreg << 8;
            if (remain == '0) begin
                valid <= 1'b0;
            end else begin
                remain <= remain - 1'b1;
            end
        end
    end

    assign tx_byte = shreg[DATA_WIDTH-1 -: 8];
    // last byte of the word currently on the output
    assign last    = valid && (remain == '0);
endmodule

// File: rtl/log_dump_ctrl.sv
// Sweeps every logger address and streams each captured word to the UART TX as bytes.
//   state | meaning
//   IDLE  | waiting for a host start command
//   ARM   | read mode requested, logger settling before first address
//   FETCH | address held, waiting RD_LATENCY cycles then capturing the word
//   SEND  | serializer emitting the captured word
//   DONE  | one-cycle done pulse, read mode released
module log_dump_ctrl
    import log_pkg::*;
#(
    parameter int ADDR_WIDTH = LOG_ADDR_WIDTH,
    parameter int DATA_WIDTH = LOG_DATA_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_mem_full,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_read_log,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [7:0]            o_byte,
    output logic                  o_byte_valid,
    input  logic                  i_byte_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    localparam int WAIT_W = $clog2(RD_LATENCY + 1);

    dump_state_t           state, state_nxt;
    logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  read_log_nxt, busy_nxt, done_nxt, err_nxt;
    logic                  load, ser_last, xfer_last;

    assign load      = (state == FETCH) && (wait_cnt == '0);
    assign xfer_last = ser_last && i_byte_ready;

    word_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk       (clk),
        .i_rst     (i_rst),
        .load      (load),
        .load_data (i_rd_data),
        .ready     (i_byte_ready),
        .tx_byte   (o_byte),
        .valid     (o_byte_valid),
        .last      (ser_last)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            o_rd_addr  <= '0;
            o_read_log <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            o_rd_addr  <= addr_nxt;
            o_read_log <= read_log_nxt;
            o_busy     <= busy_nxt;
            o_done     <= done_nxt;
            o_err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        addr_nxt     = o_rd_addr;
        read_log_nxt = o_read_log;
        busy_nxt     = o_busy;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_mem_full) begin
                        state_nxt    = ARM;
                        busy_nxt     = 1'b1;
                        read_log_nxt = 1'b1;
                        addr_nxt     = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ARM: begin
                state_nxt = FETCH;
                wait_nxt  = WAIT_W'(RD_LATENCY);
            end
            FETCH: begin
                if (wait_cnt == '0) begin
                    state_nxt = SEND;
                end else begin
                    wait_nxt = wait_cnt - 1'b1;
                end
            end
            SEND: begin
                if (xfer_last) begin
                    if (o_rd_addr == '1) begin
                        state_nxt    = DONE;
                        busy_nxt     = 1'b0;
                        read_log_nxt = 1'b0;
                        done_nxt     = 1'b1;
                        addr_nxt     = '0;
                    end else begin
                        state_nxt = FETCH;
                        addr_nxt  = o_rd_addr + 1'b1;
                        wait_nxt  = WAIT_W'(RD_LATENCY);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_log_dump_ctrl.sv
// Directed bench for log_dump_ctrl: two small instances (read latency 1 and 3) on a 4-word logger model.
module tb_log_dump_ctrl;
    logic        clk;
    logic        rst;
    logic        mem_full;
    logic        ready;

    logic        start1, read_log1, valid1, busy1, done1, err1;
    logic [1:0]  rd_addr1;
    logic [7:0]  byte1;
    logic [31:0] rd_data1;

    logic        start3, read_log3, valid3, busy3, done3, err3;
    logic [1:0]  rd_addr3;
    logic [7:0]  byte3;
    logic [31:0] rd_data3;
    logic [31:0] pipe3 [3];

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] got_q[$];
    bit         done_seen;
    int         done_gap, busy_cyc, stable_bad, rl_bad, err_cnt;
    logic       done_rl, done_busy;

    log_dump_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .RD_LATENCY(1)) dut1 (
        .clk(clk), .i_rst(rst), .i_start(start1), .i_mem_full(mem_full),
        .i_rd_data(rd_data1), .o_read_log(read_log1), .o_rd_addr(rd_addr1),
        .o_byte(byte1), .o_byte_valid(valid1), .i_byte_ready(ready),
        .o_busy(busy1), .o_done(done1), .o_err(err1)
    );

    log_dump_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .RD_LATENCY(3)) dut3 (
        .clk(clk), .i_rst(rst), .i_start(start3), .i_mem_full(mem_full),
        .i_rd_data(rd_data3), .o_read_log(read_log3), .o_rd_addr(rd_addr3),
        .o_byte(byte3), .o_byte_valid(valid3), .i_byte_ready(ready),
        .o_busy(busy3), .o_done(done3), .o_err(err3)
    );

    // Logger models: word[n] = A0B0C0D0 + n, one- and three-cycle read latency
    always_ff @(posedge clk) rd_data1 <= 32'hA0B0C0D0 + 32'(rd_addr1);
    always_ff @(posedge clk) begin
        pipe3[0] <= 32'hA0B0C0D0 + 32'(rd_addr3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign rd_data3 = pipe3[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_byte(input int k);
        logic [31:0] w;
        w = 32'hA0B0C0D0 + 32'(k / 4);
        return w[31 - 8 * (k % 4) -: 8];
    endfunction

    // Drives a dump on dut1 and records what it observes; returns at the done cycle,
    // after stop_after bytes, or when the cycle budget runs out.
    task automatic run_dump1(input int rdy_pct, input int stop_after, input int poke_at);
        int         cyc;
        int         last_x;
        bit         prev_stall;
        bit         poked;
        logic [7:0] prev_byte;
        got_q.delete();
        done_seen = 0; done_gap = -1; busy_cyc = 0; stable_bad = 0; rl_bad = 0; err_cnt = 0;
        done_rl = 1'b1; done_busy = 1'b1;
        cyc = 0; last_x = -100; prev_stall = 0; poked = 0; prev_byte = 8'h00;
        start1 = 1'b1;
        @(negedge clk);
        while (!done_seen && cyc < 3000) begin
            start1 = 1'b0;
            ready  = (int'($urandom_range(0, 99)) < rdy_pct);
            if (prev_stall && (!valid1 || byte1 !== prev_byte)) stable_bad++;
            if (busy1) busy_cyc++;
            if (busy1 && !read_log1) rl_bad++;
            if (err1) err_cnt++;
            if (done1) begin
                done_seen = 1; done_gap = cyc - last_x; done_rl = read_log1; done_busy = busy1;
            end
            if (!poked && busy1 && got_q.size() == poke_at) begin
                start1 = 1'b1; poked = 1;
            end
            prev_stall = valid1 && !ready;
            prev_byte  = byte1;
            if (valid1 && ready) begin
                got_q.push_back(byte1);
                last_x = cyc;
            end
            if (stop_after >= 0 && got_q.size() == stop_after) break;
            if (!done_seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        start1 = 1'b0;
        ready  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({read_log1, rd_addr1, byte1, valid1, busy1, done1, err1} !== 15'h0)
            $display("FAIL reset_dut1: got %h, want 0", {read_log1, rd_addr1, byte1, valid1, busy1, done1, err1});
        else n_pass++;
        n_total++;
        if ({read_log3, rd_addr3, byte3, valid3, busy3, done3, err3} !== 15'h0)
            $display("FAIL reset_dut3: got %h, want 0", {read_log3, rd_addr3, byte3, valid3, busy3, done3, err3});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_dump();
        int bad = 0;
        run_dump1(100, -1, -1);
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== exp_byte(k)) bad++;
        n_total++;
        if (got_q.size() != 16) $display("FAIL basic_count: got %0d bytes, want 16", got_q.size()); else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL basic_seq: got %0d wrong bytes, want 0", bad); else n_pass++;
        n_total++;
        if (!done_seen || done_gap != 1) $display("FAIL basic_done_gap: got seen=%0d gap=%0d, want seen=1 gap=1", done_seen, done_gap); else n_pass++;
        n_total++;
        if (busy_cyc != 25 || rl_bad != 0) $display("FAIL basic_busy_window: got busy=%0d rl_low=%0d, want 25 and 0", busy_cyc, rl_bad); else n_pass++;
        n_total++;
        if ({done_rl, done_busy} !== 2'b00) $display("FAIL basic_done_release: got rl/busy=%b, want 00", {done_rl, done_busy}); else n_pass++;
        @(negedge clk);
        n_total++;
        if ({done1, rd_addr1} !== 3'b000) $display("FAIL basic_after_done: got done/addr=%b, want 000", {done1, rd_addr1}); else n_pass++;
    endtask

    task automatic test_err();
        int cnt = 0;
        mem_full = 1'b0;
        start1   = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n_total++;
        if ({err1, read_log1, busy1} !== 3'b100) $display("FAIL err_pulse: got err/rl/busy=%b, want 100", {err1, read_log1, busy1}); else n_pass++;
        @(negedge clk);
        n_total++;
        if (err1 !== 1'b0) $display("FAIL err_one_cycle: got %b, want 0", err1); else n_pass++;
        repeat (8) begin
            @(negedge clk);
            if (valid1 || busy1 || read_log1) cnt++;
        end
        n_total++;
        if (cnt != 0) $display("FAIL err_no_dump: got %0d active cycles, want 0", cnt); else n_pass++;
        mem_full = 1'b1;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        run_dump1(30, -1, -1);
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== exp_byte(k)) bad++;
        n_total++;
        if (got_q.size() != 16 || bad != 0) $display("FAIL bp_seq: got %0d bytes %0d wrong, want 16 and 0", got_q.size(), bad); else n_pass++;
        n_total++;
        if (stable_bad != 0) $display("FAIL bp_stable: got %0d unstable stalls, want 0", stable_bad); else n_pass++;
        n_total++;
        if (!done_seen || done_gap != 1) $display("FAIL bp_done: got seen=%0d gap=%0d, want seen=1 gap=1", done_seen, done_gap); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_latency3();
        int         hold[4] = '{default: 0};
        bit         seen = 0;
        int         cyc = 0;
        int         bad = 0;
        logic [7:0] q[$];
        ready  = 1'b1;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        while (!seen && cyc < 500) begin
            if (busy3) hold[rd_addr3]++;
            if (done3) seen = 1;
            if (valid3 && ready) q.push_back(byte3);
            if (!seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        for (int k = 0; k < q.size(); k++) if (q[k] !== exp_byte(k)) bad++;
        n_total++;
        if (!seen) $display("FAIL lat3_done: got no done within %0d cycles, want done", cyc); else n_pass++;
        n_total++;
        if (q.size() != 16 || bad != 0) $display("FAIL lat3_seq: got %0d bytes %0d wrong, want 16 and 0", q.size(), bad); else n_pass++;
        n_total++;
        if (hold[0] != 9 || hold[1] != 8 || hold[2] != 8 || hold[3] != 8)
            $display("FAIL lat3_addr_hold: got %0d/%0d/%0d/%0d, want 9/8/8/8", hold[0], hold[1], hold[2], hold[3]);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort_restart();
        int dcnt = 0;
        int bad  = 0;
        run_dump1(100, 6, 2);
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== exp_byte(k)) bad++;
        n_total++;
        if (err_cnt != 0 || got_q.size() != 6 || bad != 0)
            $display("FAIL abort_ignore_start: got err=%0d bytes=%0d wrong=%0d, want 0/6/0", err_cnt, got_q.size(), bad);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({read_log1, rd_addr1, byte1, valid1, busy1, done1, err1} !== 15'h0)
            $display("FAIL abort_reset_outputs: got %h, want 0", {read_log1, rd_addr1, byte1, valid1, busy1, done1, err1});
        else n_pass++;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done1 || busy1) dcnt++;
        end
        n_total++;
        if (dcnt != 0) $display("FAIL abort_no_done: got %0d active cycles, want 0", dcnt); else n_pass++;
        run_dump1(100, -1, -1);
        bad = 0;
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== exp_byte(k)) bad++;
        n_total++;
        if (got_q.size() != 16 || bad != 0 || !done_seen)
            $display("FAIL restart_seq: got %0d bytes %0d wrong done=%0d, want 16/0/1", got_q.size(), bad, done_seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        @(negedge clk);
        run_dump1(100, -1, -1);
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== exp_byte(k)) bad++;
        n_total++;
        if (got_q.size() != 16 || bad != 0 || !done_seen)
            $display("FAIL b2b_first: got %0d bytes %0d wrong done=%0d, want 16/0/1", got_q.size(), bad, done_seen);
        else n_pass++;
        @(negedge clk);
        run_dump1(100, -1, -1);
        bad = 0;
        for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== exp_byte(k)) bad++;
        n_total++;
        if (got_q.size() != 16 || bad != 0 || !done_seen)
            $display("FAIL b2b_second: got %0d bytes %0d wrong done=%0d, want 16/0/1", got_q.size(), bad, done_seen);
        else n_pass++;
        n_total++;
        if (busy_cyc != 25) $display("FAIL b2b_busy: got %0d busy cycles, want 25", busy_cyc); else n_pass++;
    endtask

    initial begin
        rst      = 1'b1;
        start1   = 1'b0;
        start3   = 1'b0;
        mem_full = 1'b1;
        ready    = 1'b1;
        test_reset();
        test_basic_dump();
        test_err();
        test_backpressure();
        test_latency3();
        test_abort_restart();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/log_dump_ctrl.md
Name: log_dump_ctrl

Overview:
- Downstream readout stage of the dual-BRAM sample logger.
- Once the logger reports full, a host command starts this block. It sweeps every logger address, captures each 32-bit word ({I/Q sample even, I/Q sample odd}) and streams it out as bytes, MSB first, over a valid/ready byte interface to the UART TX.
- It owns the logger's read-log request and read-address inputs for the whole dump.

Parameters:
- ADDR_WIDTH, 15, logger address width; a dump covers addresses 0..2^ADDR_WIDTH-1.
- DATA_WIDTH, 32, logger read word width; must be a multiple of 8.
- RD_LATENCY, 1, clock cycles from a stable o_rd_addr to valid i_rd_data (1..4).

Ports:
- clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  single-cycle dump request from host command decoder.
- i_mem_full  in  1  logger full/readable flag.
- i_rd_data  in  DATA_WIDTH  logger read word.
- o_read_log  out  1  read-mode request to logger; level, high while dumping.
- o_rd_addr  out  ADDR_WIDTH  logger read address.
- o_byte  out  8  output byte.
- o_byte_valid  out  1  o_byte valid.
- i_byte_ready  in  1  sink accepts byte.
- o_busy  out  1  dump in progress.
- o_done  out  1  one-cycle pulse after the last byte is accepted.
- o_err  out  1  one-cycle pulse: i_start while i_mem_full=0.

Behaviour:
- Reset: state IDLE; o_read_log, o_rd_addr, o_byte, o_byte_valid, o_busy, o_done, o_err all 0; address and byte counters cleared. Reset asserted mid-dump aborts immediately with no done pulse.
- All outputs are registered.
- States: IDLE, ARM, FETCH, SEND, DONE.
- IDLE:
  - i_start & i_mem_full -> ARM, o_busy=1, o_read_log=1, o_rd_addr=0.
  - i_start & !i_mem_full -> o_err=1 for one cycle; stay in IDLE.
- ARM: one cycle, so the logger registers read mode before the first address; -> FETCH.
- FETCH:
  - o_rd_addr is held; a wait counter runs RD_LATENCY cycles, then i_rd_data is captured into the shift register.
  - o_byte = captured[DATA_WIDTH-1 -: 8], o_byte_valid=1; -> SEND.
- SEND:
  - Byte transfer occurs when o_byte_valid & i_byte_ready. On transfer the register shifts left 8 and o_byte takes the next byte.
  - o_byte and o_byte_valid are held stable while valid & !ready.
  - After DATA_WIDTH/8 transfers, o_byte_valid drops in the same edge.
  - If o_rd_addr == all-ones -> DONE; else o_rd_addr+1 -> FETCH.
  - Per-word overhead (no backpressure): RD_LATENCY+1 cycles of FETCH plus 4 SEND cycles.
- DONE: o_done=1 for one cycle; o_busy=0 and o_read_log=0 in the same cycle; -> IDLE. o_rd_addr returns to 0.
- i_start while o_busy=1 is ignored; no o_err.
- i_mem_full dropping mid-dump (logger rearmed) does not stop the dump; data is undefined but the byte count is preserved.
- The address does not wrap past all-ones; exactly 2^ADDR_WIDTH*DATA_WIDTH/8 bytes are emitted per dump.
- i_byte_ready may be high when valid=0; this has no effect.

Decomposition:
- Shared package log_pkg: state encoding constants, BYTES_PER_WORD = DATA_WIDTH/8, LOG_ADDR_WIDTH=15, LOG_DATA_WIDTH=32.
- One sub-module, word_serializer:
  - parallel load of DATA_WIDTH bits, MSB-first 8-bit valid/ready output.
  - last-byte flag.
- The FSM, wait counter and address counter stay in log_dump_ctrl.

Test Plan:
- ADDR_WIDTH=2, RD_LATENCY=1, memory model word[n]=32'hA0B0C0D0+n, i_mem_full=1, ready always 1, pulse i_start:
  - bytes A0,B0,C0,D0,A0,B0,C0,D1,...,D3, 16 bytes total.
  - o_done one cycle after the last transfer; o_read_log high from start+1 until done.
- i_start with i_mem_full=0 -> o_err pulse one cycle, no o_read_log, no bytes, o_busy stays 0.
- Random backpressure (ready 30% duty) during a dump:
  - o_byte stable while valid & !ready.
  - Byte sequence identical to the first scenario; no duplicate or dropped byte.
- RD_LATENCY=3 with model delaying data 3 cycles -> correct words captured; o_rd_addr held ≥3 cycles per word.
- Second i_start during a dump ignored; i_rst asserted after byte 6 -> all outputs 0 next cycle, no o_done; new i_start restarts from address 0, byte A0.
- Back-to-back dumps: i_start in the cycle after o_done -> second full 16-byte sequence, correct.
